wb_port_arb: RTL and testbench

- Arbiter and sequencer for the single register-file write port behind the writeback unit.
- Shares the port between two requesters:
  - A: the in-order pipeline commit (the MEM->WB result that the writeback unit produces).
  - B: the long-latency multiply/divide unit (MDU).
- Output is a registered write port. Pipeline has priority; a starvation counter guarantees MDU progress.

---
 rtl/wb_port_arb.sv | 126 ++++++++++++
 tb/tb_wb_port_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arb.sv
// Single register-file write port shared by the in-order commit path (A) and the MDU (B).
// Optional perf counters are enabled with the YSYX_23060251_WB_ARB_PERF_EN macro.
module wb_port_arb #(
    parameter int XLEN       = 32,
    parameter int RS_W       = 5,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_en_i,
    input  logic            a_valid_i,
    input  logic            a_wen_i,
    input  logic [RS_W-1:0] a_rd_i,
    input  logic [XLEN-1:0] a_data_i,
    output logic            a_ready_o,
    input  logic            b_valid_i,
    input  logic [RS_W-1:0] b_rd_i,
    input  logic [XLEN-1:0] b_data_i,
    output logic            b_ready_o,
    output logic            w_wen_o,
    output logic [RS_W-1:0] w_rd_o,
    output logic [XLEN-1:0] w_data_o,
    output logic            w_src_o
`ifdef YSYX_23060251_WB_ARB_PERF_EN
    ,
    output logic [31:0]     perf_conflict_o,
    output logic [31:0]     perf_b_wait_o
`endif
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    // Valid/ready: a transfer happens on valid && ready; requesters hold valid/rd/data
    // stable until then. Ready depends only on valid, wb_en_i, rst_n and starve_cnt_q.
    logic            b_wins;
    logic            grant_a;
    logic            grant_b;

    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic            w_wen_q, w_wen_d;
    logic [RS_W-1:0] w_rd_q, w_rd_d;
    logic [XLEN-1:0] w_data_q, w_data_d;
    logic            w_src_q, w_src_d;

    always_comb begin
        b_wins  = (starve_cnt_q >= LIM);
        grant_a = rst_n && wb_en_i && a_valid_i && !(b_valid_i && b_wins);
        grant_b = rst_n && wb_en_i && b_valid_i && (!a_valid_i || b_wins);
    end

    assign a_ready_o = grant_a;
    assign b_ready_o = grant_b;

    always_comb begin
        w_wen_d  = 1'b0;
        w_rd_d   = w_rd_q;
        w_data_d = w_data_q;
        w_src_d  = w_src_q;
        if (grant_a) begin
            // A non-writing commit still occupies the slot so tracing sees commit order.
            w_wen_d  = a_wen_i && (a_rd_i != '0);
            w_rd_d   = a_rd_i;
            w_data_d = a_data_i;
            w_src_d  = 1'b0;
        end else if (grant_b) begin
            w_wen_d  = (b_rd_i != '0);
            w_rd_d   = b_rd_i;
            w_data_d = b_data_i;
            w_src_d  = 1'b1;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_b) begin
            starve_cnt_d = 4'd0;
        end else if (b_valid_i && (starve_cnt_q != 4'hF)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
            w_wen_q      <= 1'b0;
            w_rd_q       <= '0;
            w_data_q     <= '0;
            w_src_q      <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            w_wen_q      <= w_wen_d;
            w_rd_q       <= w_rd_d;
            w_data_q     <= w_data_d;
            w_src_q      <= w_src_d;
        end
    end

    assign w_wen_o  = w_wen_q;
    assign w_rd_o   = w_rd_q;
    assign w_data_o = w_data_q;
    assign w_src_o  = w_src_q;

`ifdef YSYX_23060251_WB_ARB_PERF_EN
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic [31:0] perf_b_wait_q, perf_b_wait_d;

    always_comb begin
        perf_conflict_d = perf_conflict_q + 32'(a_valid_i && b_valid_i && wb_en_i);
        perf_b_wait_d   = perf_b_wait_q + 32'(b_valid_i && !grant_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conflict_q <= 32'd0;
            perf_b_wait_q   <= 32'd0;
        end else begin
            perf_conflict_q <= perf_conflict_d;
            perf_b_wait_q   <= perf_b_wait_d;
        end
    end

    assign perf_conflict_o = perf_conflict_q;
    assign perf_b_wait_o   = perf_b_wait_q;
`endif

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed bench for wb_port_arb: a vector table for single-cycle behaviour plus
// hand-written sequences for saturation, mid-stream reset and starvation limits 1 and 2.
module tb_wb_port_arb;

    logic        clk;
    logic        rst_n;
    logic        wb_en;
    logic        a_valid;
    logic        a_wen;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;

    logic        a_ready, b_ready, w_wen, w_src;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic        a_ready1, b_ready1, w_wen1, w_src1;
    logic [4:0]  w_rd1;
    logic [31:0] w_data1;
    logic        a_ready2, b_ready2, w_wen2, w_src2;
    logic [4:0]  w_rd2;
    logic [31:0] w_data2;
`ifdef YSYX_23060251_WB_ARB_PERF_EN
    logic [31:0] pc0, pw0, pc1, pw1, pc2, pw2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    wb_port_arb #(.XLEN(32), .RS_W(5), .STARVE_LIM(4)) dut (
        .clk(clk), .rst_n(rst_n), .wb_en_i(wb_en),
        .a_valid_i(a_valid), .a_wen_i(a_wen), .a_rd_i(a_rd), .a_data_i(a_data), .a_ready_o(a_ready),
        .b_valid_i(b_valid), .b_rd_i(b_rd), .b_data_i(b_data), .b_ready_o(b_ready),
        .w_wen_o(w_wen), .w_rd_o(w_rd), .w_data_o(w_data), .w_src_o(w_src)
`ifdef YSYX_23060251_WB_ARB_PERF_EN
        , .perf_conflict_o(pc0), .perf_b_wait_o(pw0)
`endif
    );

    wb_port_arb #(.XLEN(32), .RS_W(5), .STARVE_LIM(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wb_en_i(wb_en),
        .a_valid_i(a_valid), .a_wen_i(a_wen), .a_rd_i(a_rd), .a_data_i(a_data), .a_ready_o(a_ready1),
        .b_valid_i(b_valid), .b_rd_i(b_rd), .b_data_i(b_data), .b_ready_o(b_ready1),
        .w_wen_o(w_wen1), .w_rd_o(w_rd1), .w_data_o(w_data1), .w_src_o(w_src1)
`ifdef YSYX_23060251_WB_ARB_PERF_EN
        , .perf_conflict_o(pc1), .perf_b_wait_o(pw1)
`endif
    );

    wb_port_arb #(.XLEN(32), .RS_W(5), .STARVE_LIM(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .wb_en_i(wb_en),
        .a_valid_i(a_valid), .a_wen_i(a_wen), .a_rd_i(a_rd), .a_data_i(a_data), .a_ready_o(a_ready2),
        .b_valid_i(b_valid), .b_rd_i(b_rd), .b_data_i(b_data), .b_ready_o(b_ready2),
        .w_wen_o(w_wen2), .w_rd_o(w_rd2), .w_data_o(w_data2), .w_src_o(w_src2)
`ifdef YSYX_23060251_WB_ARB_PERF_EN
        , .perf_conflict_o(pc2), .perf_b_wait_o(pw2)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_en;
        logic        a_valid;
        logic        a_wen;
        logic [4:0]  a_rd;
        logic [31:0] a_data;
        logic        b_valid;
        logic [4:0]  b_rd;
        logic [31:0] b_data;
        logic        exp_ar;
        logic        exp_br;
        logic        exp_wen;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_src;
        logic [3:0]  exp_starve;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic av, logic aw, logic [4:0] ar, logic [31:0] ad,
                                logic bv, logic [4:0] br, logic [31:0] bd,
                                logic ear, logic ebr, logic ew, logic [4:0] erd,
                                logic [31:0] ed, logic es, logic [3:0] est);
        vec_t v;
        v.wb_en = en; v.a_valid = av; v.a_wen = aw; v.a_rd = ar; v.a_data = ad;
        v.b_valid = bv; v.b_rd = br; v.b_data = bd;
        v.exp_ar = ear; v.exp_br = ebr; v.exp_wen = ew; v.exp_rd = erd;
        v.exp_data = ed; v.exp_src = es; v.exp_starve = est;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic av, input logic aw, input logic [4:0] ar,
                         input logic [31:0] ad, input logic bv, input logic [4:0] br,
                         input logic [31:0] bd);
        wb_en = en; a_valid = av; a_wen = aw; a_rd = ar; a_data = ad;
        b_valid = bv; b_rd = br; b_data = bd;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        string tag;
        rst_n = 1'b1;
        do_reset();

        // Reset state
        #1;
        chk("reset_wen", 32'(w_wen), 32'd0);
        chk("reset_rd", 32'(w_rd), 32'd0);
        chk("reset_data", w_data, 32'd0);
        chk("reset_src", 32'(w_src), 32'd0);
        chk("reset_starve", 32'(dut.starve_cnt_q), 32'd0);

        // Vector table, STARVE_LIM=4 instance
        vecs.push_back(mk(1,1,1,5'd5,32'h1234, 0,5'd0,32'h0,      1,0,1,5'd5,32'h1234,0,4'd0));
        vecs.push_back(mk(1,0,0,5'd0,32'h0,    1,5'd0,32'hFFFF,   0,1,0,5'd0,32'hFFFF,1,4'd0));
        vecs.push_back(mk(1,0,0,5'd0,32'h0,    0,5'd0,32'h0,      0,0,0,5'd0,32'hFFFF,1,4'd0));
        vecs.push_back(mk(1,1,0,5'd7,32'hAA,   0,5'd0,32'h0,      1,0,0,5'd7,32'hAA,0,4'd0));
        vecs.push_back(mk(1,1,1,5'd0,32'h55,   0,5'd0,32'h0,      1,0,0,5'd0,32'h55,0,4'd0));
        vecs.push_back(mk(1,0,0,5'd0,32'h0,    1,5'd3,32'h33,     0,1,1,5'd3,32'h33,1,4'd0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,1,1,5'd1,32'h100+i, 1,5'd9,32'h99, 1,0,1,5'd1,32'h100+i,0,4'(i+1)));
        vecs.push_back(mk(1,1,1,5'd1,32'h104,  1,5'd9,32'h99,     0,1,1,5'd9,32'h99,1,4'd0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,1,1,5'd1,32'h104+i, 1,5'd10,32'h9A, 1,0,1,5'd1,32'h104+i,0,4'(i+1)));
        vecs.push_back(mk(1,1,1,5'd1,32'h108,  1,5'd10,32'h9A,    0,1,1,5'd10,32'h9A,1,4'd0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,1,5'd2,32'h200, 1,5'd11,32'hBB, 0,0,0,5'd10,32'h9A,1,4'(i+1)));
        vecs.push_back(mk(1,1,1,5'd2,32'h200,  1,5'd11,32'hBB,    1,0,1,5'd2,32'h200,0,4'd4));
        vecs.push_back(mk(1,1,1,5'd2,32'h201,  1,5'd11,32'hBB,    0,1,1,5'd11,32'hBB,1,4'd0));

        foreach (vecs[i]) begin
            drive(vecs[i].wb_en, vecs[i].a_valid, vecs[i].a_wen, vecs[i].a_rd, vecs[i].a_data,
                  vecs[i].b_valid, vecs[i].b_rd, vecs[i].b_data);
            #1;
            tag = $sformatf("v%0d", i);
            chk({tag, "_a_ready"}, 32'(a_ready), 32'(vecs[i].exp_ar));
            chk({tag, "_b_ready"}, 32'(b_ready), 32'(vecs[i].exp_br));
            @(posedge clk);
            #1;
            chk({tag, "_wen"}, 32'(w_wen), 32'(vecs[i].exp_wen));
            chk({tag, "_rd"}, 32'(w_rd), 32'(vecs[i].exp_rd));
            chk({tag, "_data"}, w_data, vecs[i].exp_data);
            chk({tag, "_src"}, 32'(w_src), 32'(vecs[i].exp_src));
            chk({tag, "_starve"}, 32'(dut.starve_cnt_q), 32'(vecs[i].exp_starve));
        end

        // Saturation at 15 with the port disabled, hold when B idle, clear on B transfer
        drive(0, 0, 0, 5'd0, 32'h0, 1, 5'd12, 32'hC0);
        repeat (17) @(posedge clk);
        #1;
        chk("sat_starve", 32'(dut.starve_cnt_q), 32'd15);
        chk("sat_b_ready", 32'(b_ready), 32'd0);
        drive(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        chk("sat_hold", 32'(dut.starve_cnt_q), 32'd15);
        drive(1, 0, 0, 5'd0, 32'h0, 1, 5'd12, 32'hC0);
        #1;
        chk("sat_b_grant", 32'(b_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("sat_clear", 32'(dut.starve_cnt_q), 32'd0);
        chk("sat_data", w_data, 32'hC0);

        // Mid-stream reset while B waits with starve_cnt=3
        drive(1, 1, 1, 5'd4, 32'hDEAD, 0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        drive(0, 1, 1, 5'd6, 32'h66, 1, 5'd13, 32'hD0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pre_starve", 32'(dut.starve_cnt_q), 32'd3);
        chk("rst_pre_data", w_data, 32'hDEAD);
        wb_en = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_wen", 32'(w_wen), 32'd0);
        chk("rst_rd", 32'(w_rd), 32'd0);
        chk("rst_data", w_data, 32'd0);
        chk("rst_src", 32'(w_src), 32'd0);
        chk("rst_starve", 32'(dut.starve_cnt_q), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a_valid = 1'b0;
        #1;
        chk("rel_b_ready", 32'(b_ready), 32'd1);
        chk("rel_a_ready", 32'(a_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_wen", 32'(w_wen), 32'd1);
        chk("rel_rd", 32'(w_rd), 32'd13);
        chk("rel_src", 32'(w_src), 32'd1);

        // Continuous conflict: LIM=1 alternates, LIM=2 gives A,A,B
        do_reset();
        drive(1, 1, 1, 5'd8, 32'h80, 1, 5'd14, 32'hE0);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("lim1_b_ready_c%0d", c), 32'(b_ready1), 32'(c % 2 == 1));
            chk($sformatf("lim1_a_ready_c%0d", c), 32'(a_ready1), 32'(c % 2 == 0));
            chk($sformatf("lim2_b_ready_c%0d", c), 32'(b_ready2), 32'(c % 3 == 2));
            chk($sformatf("lim4_b_ready_c%0d", c), 32'(b_ready), 32'(c == 4));
            @(posedge clk);
        end
`ifdef YSYX_23060251_WB_ARB_PERF_EN
        #1;
        chk("perf_conflict", pc2, 32'd6);
        chk("perf_b_wait", pw2, 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
